// File: rtl/az_sequencer_pkg.sv
// Shared definitions for the auto-zero sequencer: conditioning-vector field
// layout, counter width and FSM state encoding.
package az_sequencer_pkg;

  localparam int AZ_NUM_BITS = 22;
  localparam int AZ_CNT_W    = 24;

  localparam int AZMUX_LSB   = 0;
  localparam int HIMUX_LSB   = 4;
  localparam int HIMUX2_LSB  = 8;
  localparam int PCSW_BIT    = 12;
  localparam int LED0_BIT    = 13;
  localparam int MONITOR_LSB = 14;

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    SIG_SETTLE = 3'd1,
    SIG_APER   = 3'd2,
    LO_SETTLE  = 3'd3,
    LO_APER    = 3'd4
  } azState_t;

  typedef struct packed {
    logic [3:0] azmuxSig;
    logic [3:0] azmuxLo;
    logic [3:0] himux;
    logic [3:0] himux2;
  } muxCfg_t;

endpackage

// File: rtl/az_sequencer_phase_timer.sv
// Phase duration timer: loads max(n,1) on entry to a timed state and flags
// the last clock of that state; doneNext is the value done takes next clock.
module az_sequencer_phase_timer
  import az_sequencer_pkg::*;
#(
  parameter int CNT_W = AZ_CNT_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [CNT_W-1:0] n,
  output logic             done,
  output logic             doneNext
);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] lim_q, lim_d;
  logic             done_q, done_d;
  logic [CNT_W-1:0] nMinus1;

  // A zero length is stretched to one clock, so the limit never underflows.
  assign nMinus1 = (n == '0) ? '0 : n - CNT_W'(1);

  always_comb begin
    cnt_d  = cnt_q;
    lim_d  = lim_q;
    done_d = done_q;
    if (load) begin
      cnt_d  = '0;
      lim_d  = nMinus1;
      done_d = (nMinus1 == '0);
    end else if (cnt_q != lim_q) begin
      cnt_d  = cnt_q + CNT_W'(1);
      done_d = (cnt_d == lim_q);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q  <= '0;
      lim_q  <= '0;
      done_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      lim_q  <= lim_d;
      done_q <= done_d;
    end
  end

  assign done     = done_q;
  assign doneNext = done_d;

endmodule

// File: rtl/az_sequencer.sv
// Auto-zero modulation sequencer: alternates azmux between signal and lo
// phases (settle + aperture each). Define AZ_SEQ_MONITOR_EN to drive the monitor byte.
module az_sequencer
  import az_sequencer_pkg::*;
#(
  parameter int NUM_BITS = AZ_NUM_BITS,
  parameter int CNT_W    = AZ_CNT_W
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                enable,
  input  logic [3:0]          cfg_azmux_sig,
  input  logic [3:0]          cfg_azmux_lo,
  input  logic [3:0]          cfg_himux,
  input  logic [3:0]          cfg_himux2,
  input  logic [CNT_W-1:0]    cfg_settle,
  input  logic [CNT_W-1:0]    cfg_aper,
  output logic [NUM_BITS-1:0] out,
  output logic                busy,
  output logic                phase_sig,
  output logic                aper_active,
  output logic                sample_done
);

  azState_t         state_q, state_d;
  muxCfg_t          shadow_q, shadow_d, cfgIn;
  logic [CNT_W-1:0] shSettle_q, shSettle_d;
  logic [CNT_W-1:0] shAper_q, shAper_d;
  logic             stopReq_q, stopReq_d;
  logic             led0_q, led0_d;
  logic             stopNow, relatch;
  logic             timerLoad, timerDone, timerDoneNext;
  logic [CNT_W-1:0] timerN;
  logic [NUM_BITS-1:0] out_d;
  logic             busy_d, phaseSig_d, aperActive_d, sampleDone_d;

  assign cfgIn   = {cfg_azmux_sig, cfg_azmux_lo, cfg_himux, cfg_himux2};
  assign stopNow = stopReq_q || !enable;

  // Apertures are never cut short; a stop request only takes effect at aperture end.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:       if (enable)    state_d = SIG_SETTLE;
      SIG_SETTLE: if (timerDone) state_d = SIG_APER;
      SIG_APER:   if (timerDone) state_d = stopNow ? IDLE : LO_SETTLE;
      LO_SETTLE:  if (timerDone) state_d = LO_APER;
      LO_APER:    if (timerDone) state_d = stopNow ? IDLE : SIG_SETTLE;
      default:                   state_d = IDLE;
    endcase
  end

  assign relatch    = (state_d == SIG_SETTLE) && (state_q != SIG_SETTLE);
  assign shadow_d   = relatch ? cfgIn      : shadow_q;
  assign shSettle_d = relatch ? cfg_settle : shSettle_q;
  assign shAper_d   = relatch ? cfg_aper   : shAper_q;
  assign stopReq_d  = (state_d == IDLE) ? 1'b0 : (stopReq_q || !enable);
  assign led0_d     = (state_q == LO_APER && timerDone) ? ~led0_q : led0_q;

  assign timerLoad = (state_d != state_q) && (state_d != IDLE);
  assign timerN    = (state_d == SIG_SETTLE || state_d == LO_SETTLE) ? shSettle_d : shAper_d;

  az_sequencer_phase_timer #(
    .CNT_W(CNT_W)
  ) u_timer (
    .clk     (clk),
    .reset   (reset),
    .load    (timerLoad),
    .n       (timerN),
    .done    (timerDone),
    .doneNext(timerDoneNext)
  );

  assign busy_d       = (state_d != IDLE);
  assign phaseSig_d   = (state_d == SIG_SETTLE) || (state_d == SIG_APER);
  assign aperActive_d = (state_d == SIG_APER) || (state_d == LO_APER);
  assign sampleDone_d = aperActive_d && timerDoneNext;

  // Outputs are built from next-state values so they register on the state edge.
  always_comb begin
    out_d = '0;
    if (state_d != IDLE) begin
      out_d[AZMUX_LSB +: 4]  = phaseSig_d ? shadow_d.azmuxSig : shadow_d.azmuxLo;
      out_d[HIMUX_LSB +: 4]  = shadow_d.himux;
      out_d[HIMUX2_LSB +: 4] = shadow_d.himux2;
      out_d[PCSW_BIT]        = phaseSig_d;
      out_d[LED0_BIT]        = led0_d;
`ifdef AZ_SEQ_MONITOR_EN
      out_d[MONITOR_LSB +: 8] = {sampleDone_d, aperActive_d, phaseSig_d, busy_d,
                                 1'b0, state_d};
`else
      out_d[MONITOR_LSB +: 8] = 8'h00;
`endif
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      shadow_q    <= '0;
      shSettle_q  <= '0;
      shAper_q    <= '0;
      stopReq_q   <= 1'b0;
      led0_q      <= 1'b0;
      out         <= '0;
      busy        <= 1'b0;
      phase_sig   <= 1'b0;
      aper_active <= 1'b0;
      sample_done <= 1'b0;
    end else begin
      state_q     <= state_d;
      shadow_q    <= shadow_d;
      shSettle_q  <= shSettle_d;
      shAper_q    <= shAper_d;
      stopReq_q   <= stopReq_d;
      led0_q      <= led0_d;
      out         <= out_d;
      busy        <= busy_d;
      phase_sig   <= phaseSig_d;
      aper_active <= aperActive_d;
      sample_done <= sampleDone_d;
    end
  end

endmodule

// File: tb/tb_az_sequencer.sv
// Scoreboard bench for az_sequencer: each scenario queues the expected
// per-clock output word, then pops and compares once per clock.
`timescale 1ns/1ps
module tb_az_sequencer;

  localparam int CNT_W = 24;
  localparam int ST_IDLE = 0, ST_SS = 1, ST_SA = 2, ST_LS = 3, ST_LA = 4;

  logic             clk = 1'b0;
  logic             reset, enable;
  logic [3:0]       cfgSig, cfgLo, cfgHm, cfgHm2;
  logic [CNT_W-1:0] cfgSettle, cfgAper;
  logic [21:0]      out;
  logic             busy, phaseSig, aperActive, sampleDone;

  logic [25:0] expQ[$];
  int          checks = 0;
  int          failures = 0;

  always #25 clk = ~clk;

  az_sequencer dut (
    .clk          (clk),
    .reset        (reset),
    .enable       (enable),
    .cfg_azmux_sig(cfgSig),
    .cfg_azmux_lo (cfgLo),
    .cfg_himux    (cfgHm),
    .cfg_himux2   (cfgHm2),
    .cfg_settle   (cfgSettle),
    .cfg_aper     (cfgAper),
    .out          (out),
    .busy         (busy),
    .phase_sig    (phaseSig),
    .aper_active  (aperActive),
    .sample_done  (sampleDone)
  );

  // Expected {out, busy, phase_sig, aper_active, sample_done} for one clock.
  function automatic logic [25:0] expWord(input int st, input logic [3:0] azS,
      input logic [3:0] azL, input logic [3:0] hm, input logic [3:0] hm2,
      input logic led, input logic sd);
    logic [7:0] mon;
    logic ph, ap;
    if (st == ST_IDLE) return '0;
    ph  = (st == ST_SS) || (st == ST_SA);
    ap  = (st == ST_SA) || (st == ST_LA);
    mon = 8'h00;
`ifdef AZ_SEQ_MONITOR_EN
    mon = {sd, ap, ph, 1'b1, 1'b0, 3'(st)};
`endif
    return {mon, led, ph, hm2, hm, (ph ? azS : azL), 1'b1, ph, ap, sd};
  endfunction

  task automatic pushPhase(input int st, input int n, input logic led,
      input logic [3:0] azS, input logic [3:0] azL, input logic [3:0] hm,
      input logic [3:0] hm2);
    for (int i = 0; i < n; i++)
      expQ.push_back(expWord(st, azS, azL, hm, hm2, led,
                             ((st == ST_SA) || (st == ST_LA)) && (i == n - 1)));
  endtask

  task automatic pushCycle(input int s, input int a, input logic led,
      input logic [3:0] azS, input logic [3:0] azL, input logic [3:0] hm,
      input logic [3:0] hm2);
    int se, ae;
    se = (s == 0) ? 1 : s;
    ae = (a == 0) ? 1 : a;
    pushPhase(ST_SS, se, led, azS, azL, hm, hm2);
    pushPhase(ST_SA, ae, led, azS, azL, hm, hm2);
    pushPhase(ST_LS, se, led, azS, azL, hm, hm2);
    pushPhase(ST_LA, ae, led, azS, azL, hm, hm2);
  endtask

  task automatic test_reset();
    logic [25:0] e, obs;
    cfgSig = 4'b1000; cfgLo = 4'b1011; cfgHm = 4'b0101; cfgHm2 = 4'b0011;
    cfgSettle = 3; cfgAper = 5;
    for (int i = 0; i < 6; i++) expQ.push_back('0);
    for (int i = 0; expQ.size() > 0; i++) begin
      @(negedge clk);
      e   = expQ.pop_front();
      obs = {out, busy, phaseSig, aperActive, sampleDone};
      checks++;
      if (obs !== e) begin
        failures++;
        $display("[TB] FAIL reset_hold cyc=%0d got=%h exp=%h", i, obs, e);
      end
      enable = ~enable;
    end
    reset  = 1'b0;
    enable = 1'b0;
  endtask

  task automatic test_basic();
    logic [25:0] e, obs;
    @(negedge clk);
    cfgSig = 4'b1000; cfgLo = 4'b1011; cfgHm = 4'b0101; cfgHm2 = 4'b0011;
    cfgSettle = 3; cfgAper = 5;
    enable = 1'b1;
    pushCycle(3, 5, 1'b0, 4'b1000, 4'b1011, 4'b0101, 4'b0011);
    pushCycle(3, 5, 1'b1, 4'b1000, 4'b1011, 4'b0101, 4'b0011);
    expQ.push_back('0);
    for (int i = 0; expQ.size() > 0; i++) begin
      @(negedge clk);
      e   = expQ.pop_front();
      obs = {out, busy, phaseSig, aperActive, sampleDone};
      checks++;
      if (obs !== e) begin
        failures++;
        $display("[TB] FAIL basic cyc=%0d got=%h exp=%h", i, obs, e);
      end
      if (i == 31) enable = 1'b0;
    end
  endtask

  task automatic test_min_timing();
    logic [25:0] e, obs;
    @(negedge clk);
    cfgSig = 4'b1001; cfgLo = 4'b1110; cfgHm = 4'b1010; cfgHm2 = 4'b0110;
    cfgSettle = 0; cfgAper = 0;
    enable = 1'b1;
    pushCycle(0, 0, 1'b0, 4'b1001, 4'b1110, 4'b1010, 4'b0110);
    pushCycle(0, 0, 1'b1, 4'b1001, 4'b1110, 4'b1010, 4'b0110);
    pushCycle(0, 0, 1'b0, 4'b1001, 4'b1110, 4'b1010, 4'b0110);
    expQ.push_back('0);
    pushCycle(0, 0, 1'b1, 4'b1001, 4'b1110, 4'b1010, 4'b0110);
    expQ.push_back('0);
    for (int i = 0; expQ.size() > 0; i++) begin
      @(negedge clk);
      e   = expQ.pop_front();
      obs = {out, busy, phaseSig, aperActive, sampleDone};
      checks++;
      if (obs !== e) begin
        failures++;
        $display("[TB] FAIL min_timing cyc=%0d got=%h exp=%h", i, obs, e);
      end
      if (i == 11) enable = 1'b0;
      if (i == 12) enable = 1'b1;
      if (i == 16) enable = 1'b0;
    end
  endtask

  task automatic test_cfg_change();
    logic [25:0] e, obs;
    @(negedge clk);
    cfgSig = 4'b1000; cfgLo = 4'b1011; cfgHm = 4'b0101; cfgHm2 = 4'b0011;
    cfgSettle = 3; cfgAper = 5;
    enable = 1'b1;
    pushCycle(3, 5, 1'b0, 4'b1000, 4'b1011, 4'b0101, 4'b0011);
    pushCycle(3, 9, 1'b1, 4'b1100, 4'b1011, 4'b0101, 4'b0011);
    expQ.push_back('0);
    for (int i = 0; expQ.size() > 0; i++) begin
      @(negedge clk);
      e   = expQ.pop_front();
      obs = {out, busy, phaseSig, aperActive, sampleDone};
      checks++;
      if (obs !== e) begin
        failures++;
        $display("[TB] FAIL cfg_change cyc=%0d got=%h exp=%h", i, obs, e);
      end
      if (i == 4) begin
        cfgAper = 9;
        cfgSig  = 4'b1100;
      end
      if (i == 39) enable = 1'b0;
    end
  endtask

  task automatic test_stop_in_settle();
    logic [25:0] e, obs;
    @(negedge clk);
    cfgSig = 4'b1000; cfgLo = 4'b1011; cfgHm = 4'b0101; cfgHm2 = 4'b0011;
    cfgSettle = 3; cfgAper = 5;
    enable = 1'b1;
    pushPhase(ST_SS, 3, 1'b0, 4'b1000, 4'b1011, 4'b0101, 4'b0011);
    pushPhase(ST_SA, 5, 1'b0, 4'b1000, 4'b1011, 4'b0101, 4'b0011);
    expQ.push_back('0);
    expQ.push_back('0);
    for (int i = 0; expQ.size() > 0; i++) begin
      @(negedge clk);
      e   = expQ.pop_front();
      obs = {out, busy, phaseSig, aperActive, sampleDone};
      checks++;
      if (obs !== e) begin
        failures++;
        $display("[TB] FAIL stop_in_settle cyc=%0d got=%h exp=%h", i, obs, e);
      end
      if (i == 0) enable = 1'b0;
    end
  endtask

  task automatic test_reset_mid_aper();
    logic [25:0] e, obs;
    @(negedge clk);
    cfgSig = 4'b1000; cfgLo = 4'b1011; cfgHm = 4'b0101; cfgHm2 = 4'b0011;
    cfgSettle = 3; cfgAper = 5;
    enable = 1'b1;
    pushCycle(3, 5, 1'b0, 4'b1000, 4'b1011, 4'b0101, 4'b0011);
    pushCycle(3, 5, 1'b1, 4'b1000, 4'b1011, 4'b0101, 4'b0011);
    // Stop three clocks short so reset lands with LO_APER mid-count.
    for (int i = 0; expQ.size() > 3; i++) begin
      @(negedge clk);
      e   = expQ.pop_front();
      obs = {out, busy, phaseSig, aperActive, sampleDone};
      checks++;
      if (obs !== e) begin
        failures++;
        $display("[TB] FAIL pre_reset cyc=%0d got=%h exp=%h", i, obs, e);
      end
    end
    expQ.delete();
    #5 reset = 1'b1;
    #1;
    obs = {out, busy, phaseSig, aperActive, sampleDone};
    checks++;
    if (obs !== 26'd0) begin
      failures++;
      $display("[TB] FAIL async_reset got=%h exp=%h", obs, 26'd0);
    end
    @(negedge clk);
    reset = 1'b0;
    pushCycle(3, 5, 1'b0, 4'b1000, 4'b1011, 4'b0101, 4'b0011);
    expQ.push_back('0);
    for (int i = 0; expQ.size() > 0; i++) begin
      @(negedge clk);
      e   = expQ.pop_front();
      obs = {out, busy, phaseSig, aperActive, sampleDone};
      checks++;
      if (obs !== e) begin
        failures++;
        $display("[TB] FAIL post_reset cyc=%0d got=%h exp=%h", i, obs, e);
      end
      if (i == 15) enable = 1'b0;
    end
  endtask

  initial begin
    reset  = 1'b1;
    enable = 1'b0;
    cfgSig = '0; cfgLo = '0; cfgHm = '0; cfgHm2 = '0;
    cfgSettle = '0; cfgAper = '0;
    test_reset();
    test_basic();
    test_min_timing();
    test_cfg_change();
    test_stop_in_settle();
    test_reset_mid_aper();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
    $fatal(1, "[TB] watchdog");
  end

endmodule
